ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter SPI_ADDR_BITS, default 32, SPI slave address width.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 16, RAM port address width.
REQ-003 SHALL have ports, in this order:
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU memory request (level); held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  RAM_ADDR_BITS  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait_n  out  1  low stalls the CPU.
- spi_wr  in  1  one-cycle SPI write strobe.
- spi_rd  in  1  one-cycle SPI read strobe.
- spi_addr  in  SPI_ADDR_BITS  SPI address; [31:24] selects the target.
- spi_din  in  8  SPI write data.
- spi_dout  out  8  SPI read data; valid with spi_rvalid.
- spi_rvalid  out  1  one-cycle SPI read-data pulse.
- spi_ovf  out  1  sticky flag: SPI strobe dropped.
- cpu_control  out  8  control register; bit 1 = loading.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_ADDR_BITS  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, registered, one-cycle latency.

Function
REQ-004 SHALL decode SPI targets from spi_addr[31:24]:
- 0x00: RAM.
- 0xFF: spi_wr loads cpu_control from spi_din in the same cycle; spi_rd returns cpu_control on spi_dout with spi_rvalid the next cycle; no RAM access.
- Any other value: ignored.
REQ-005 SHALL capture each RAM-targeted SPI strobe (type, addr[15:0], data) into a one-entry pending buffer.
REQ-006 SHALL drop a strobe that arrives while the buffer is occupied and not being retired that cycle, and SHALL set spi_ovf.
REQ-007 SHALL drive loading = cpu_control[1], and cpu_wait_n = ~loading & ~(cpu_req & ~cpu_ack).
REQ-008 SHALL implement FSM states IDLE, CPU_ACC, CPU_DONE, SPI_ACC, SPI_RDONE.
REQ-009 IDLE transitions:
- To SPI_ACC if the buffer is pending and (last grant was CPU, or cpu_req=0, or loading=1).
- Otherwise to CPU_ACC if cpu_req=1 and loading=0.
- Otherwise stay in IDLE.
REQ-010 CPU_ACC: drive ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we for exactly one cycle, then go to CPU_DONE.
REQ-011 CPU_DONE: register cpu_dout <= ram_dout (reads only), pulse cpu_ack, set last grant = CPU, go to IDLE. Latency from IDLE grant cycle to cpu_ack is 2 cycles.
REQ-012 SPI_ACC: drive RAM from the buffer for one cycle.
- Write: free the buffer, set last grant = SPI, go to IDLE.
- Read: go to SPI_RDONE.
REQ-013 SPI_RDONE: register spi_dout <= ram_dout, pulse spi_rvalid, free the buffer, set last grant = SPI, go to IDLE.
REQ-014 SHALL drive ram_we=0 in every state except CPU_ACC and SPI_ACC; ram_addr and ram_din hold their last values.
REQ-015 A CPU access, once granted, SHALL complete even if cpu_req falls or loading rises mid-access.
REQ-016 A strobe arriving in the same cycle the buffer frees SHALL be accepted, not dropped.
REQ-017 Under continuous CPU and SPI demand, grants SHALL strictly alternate; neither requester waits more than one foreign access.

Reset
REQ-018 While reset is high, the block SHALL force:
- State IDLE, buffer empty, last grant = SPI.
- cpu_control=0x00, cpu_dout=0x00, spi_dout=0x00.
- cpu_ack=0, spi_rvalid=0, spi_ovf=0, ram_we=0, ram_addr=0, ram_din=0.
- cpu_wait_n follows REQ-007 (1 while cpu_req=0).
REQ-019 Reset asserted mid-access SHALL abort the access immediately: no ack pulse and no further RAM write.

Configuration
REQ-020 With macro RAM_ARBITER_ROM_WP_EN defined:
- A CPU write with cpu_addr[15:14]=00 SHALL complete with normal timing and cpu_ack, but ram_we SHALL stay 0.
- SPI writes to that range are unaffected.
REQ-021 Without the macro, CPU writes to all addresses SHALL reach RAM.

Verification
REQ-022 CPU read of 0x4000 holding 0xA5, no SPI traffic -> cpu_ack 2 cycles after grant, cpu_dout=0xA5, cpu_wait_n low until the ack cycle.
REQ-023 spi_wr at 0xFF000000 with data 0x02 -> cpu_control=0x02, cpu_wait_n=0; a following SPI write of 0x3C to 0x00005800 -> RAM[0x5800]=0x3C.
REQ-024 cpu_req held continuously and SPI strobes every 4 cycles -> grants alternate CPU/SPI, no strobe dropped, spi_ovf=0.
REQ-025 Two spi_wr strobes in consecutive cycles while a CPU access is in flight -> first performed, second dropped, spi_ovf=1 until reset.
REQ-026 With RAM_ARBITER_ROM_WP_EN: CPU write of 0xFF to 0x0010 -> cpu_ack pulses, RAM[0x0010] unchanged. Without the macro -> RAM[0x0010]=0xFF.
REQ-027 reset pulsed during CPU_ACC of a write -> no cpu_ack, all outputs at REQ-018 values, next request served normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous-read RAM port between a CPU and an SPI slave.
// Define RAM_ARBITER_ROM_WP_EN to block CPU writes to 0x0000-0x3FFF.
module ram_arbiter #(
  parameter int SPI_ADDR_BITS = 32,
  parameter int RAM_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [RAM_ADDR_BITS-1:0] cpu_addr,
  input  logic [7:0]               cpu_din,
  output logic [7:0]               cpu_dout,
  output logic                     cpu_ack,
  output logic                     cpu_wait_n,
  input  logic                     spi_wr,
  input  logic                     spi_rd,
  input  logic [SPI_ADDR_BITS-1:0] spi_addr,
  input  logic [7:0]               spi_din,
  output logic [7:0]               spi_dout,
  output logic                     spi_rvalid,
  output logic                     spi_ovf,
  output logic [7:0]               cpu_control,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [7:0]               ram_din,
  input  logic [7:0]               ram_dout
);

  typedef enum logic [2:0] {
    IDLE, CPU_ACC, CPU_DONE, SPI_ACC, SPI_RDONE
  } state_t;

  state_t state_q, state_d;

  logic                     pend_q, pend_d;
  logic                     pwr_q, pwr_d;
  logic [15:0]              paddr_q, paddr_d;
  logic [7:0]               pdat_q, pdat_d;
  logic                     last_spi_q, last_spi_d;
  logic                     cwe_q, cwe_d;
  logic [7:0]               ctrl_q, ctrl_d;
  logic [7:0]               cdout_q, cdout_d;
  logic [7:0]               sdout_q, sdout_d;
  logic                     cack_q, cack_d;
  logic                     rvld_q, rvld_d;
  logic                     ovf_q, ovf_d;
  logic                     rwe_q, rwe_d;
  logic [RAM_ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [7:0]               rdin_q, rdin_d;

  logic loading, creq, sel_ram, sel_ctl, free, cpu_wp;
  logic unused_spi;

  assign loading = ctrl_q[1];
  // The ack cycle still shows the finished request; it must not be granted twice.
  assign creq    = cpu_req & ~cack_q & ~loading;
  assign sel_ram = spi_addr[31:24] == 8'h00;
  assign sel_ctl = spi_addr[31:24] == 8'hFF;
  assign free    = (state_q == SPI_ACC && pwr_q) || (state_q == SPI_RDONE);
  assign unused_spi = ^spi_addr[23:16];

`ifdef RAM_ARBITER_ROM_WP_EN
  assign cpu_wp = cpu_addr[15:14] == 2'b00;
`else
  assign cpu_wp = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pwr_d      = pwr_q;
    paddr_d    = paddr_q;
    pdat_d     = pdat_q;
    last_spi_d = last_spi_q;
    cwe_d      = cwe_q;
    ctrl_d     = ctrl_q;
    cdout_d    = cdout_q;
    sdout_d    = sdout_q;
    cack_d     = 1'b0;
    rvld_d     = 1'b0;
    ovf_d      = ovf_q;
    rwe_d      = 1'b0;
    raddr_d    = raddr_q;
    rdin_d     = rdin_q;

    if (free) pend_d = 1'b0;
    if ((spi_wr | spi_rd) && sel_ram) begin
      if (!pend_q || free) begin
        pend_d  = 1'b1;
        pwr_d   = spi_wr;
        paddr_d = spi_addr[15:0];
        pdat_d  = spi_din;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (spi_wr && sel_ctl) ctrl_d = spi_din;
    if (spi_rd && sel_ctl) begin
      sdout_d = ctrl_q;
      rvld_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_q && (!last_spi_q || !creq)) begin
          state_d = SPI_ACC;
          rwe_d   = pwr_q;
          raddr_d = RAM_ADDR_BITS'(paddr_q);
          rdin_d  = pdat_q;
        end else if (creq) begin
          state_d = CPU_ACC;
          rwe_d   = cpu_we & ~cpu_wp;
          raddr_d = cpu_addr;
          rdin_d  = cpu_din;
          cwe_d   = cpu_we;
        end
      end
      CPU_ACC: state_d = CPU_DONE;
      CPU_DONE: begin
        if (!cwe_q) cdout_d = ram_dout;
        cack_d     = 1'b1;
        last_spi_d = 1'b0;
        state_d    = IDLE;
      end
      SPI_ACC: begin
        if (pwr_q) begin
          last_spi_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = SPI_RDONE;
        end
      end
      SPI_RDONE: begin
        sdout_d    = ram_dout;
        rvld_d     = 1'b1;
        last_spi_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pwr_q      <= 1'b0;
      paddr_q    <= '0;
      pdat_q     <= '0;
      last_spi_q <= 1'b1;
      cwe_q      <= 1'b0;
      ctrl_q     <= '0;
      cdout_q    <= '0;
      sdout_q    <= '0;
      cack_q     <= 1'b0;
      rvld_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rwe_q      <= 1'b0;
      raddr_q    <= '0;
      rdin_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pwr_q      <= pwr_d;
      paddr_q    <= paddr_d;
      pdat_q     <= pdat_d;
      last_spi_q <= last_spi_d;
      cwe_q      <= cwe_d;
      ctrl_q     <= ctrl_d;
      cdout_q    <= cdout_d;
      sdout_q    <= sdout_d;
      cack_q     <= cack_d;
      rvld_q     <= rvld_d;
      ovf_q      <= ovf_d;
      rwe_q      <= rwe_d;
      raddr_q    <= raddr_d;
      rdin_q     <= rdin_d;
    end
  end

  assign cpu_dout    = cdout_q;
  assign cpu_ack     = cack_q;
  assign cpu_wait_n  = ~loading & ~(cpu_req & ~cack_q);
  assign spi_dout    = sdout_q;
  assign spi_rvalid  = rvld_q;
  assign spi_ovf     = ovf_q;
  assign cpu_control = ctrl_q;
  assign ram_we      = rwe_q;
  assign ram_addr    = raddr_q;
  assign ram_din     = rdin_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + randomized checks of ram_arbiter against a
// byte-array memory model and the arbitration rules.
module tb_ram_arbiter;

  localparam int ACK_SAMPLES = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack, cpu_wait_n;
  logic        spi_wr = 1'b0, spi_rd = 1'b0;
  logic [31:0] spi_addr = '0;
  logic [7:0]  spi_din = '0;
  logic [7:0]  spi_dout;
  logic        spi_rvalid, spi_ovf;
  logic [7:0]  cpu_control;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:65535];
  bit         wr_v [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         glog [$];
  bit         log_en = 1'b0;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .cpu_wait_n(cpu_wait_n),
    .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr),
    .spi_din(spi_din), .spi_dout(spi_dout), .spi_rvalid(spi_rvalid),
    .spi_ovf(spi_ovf), .cpu_control(cpu_control),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(logic [15:0] a);
    return wr_v[a] ? mem[a] : init_byte(a);
  endfunction

  // Synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]  <= ram_din;
      wr_v[ram_addr] <= 1'b1;
    end
    ram_dout <= wr_v[ram_addr] ? mem[ram_addr] : init_byte(ram_addr);
    if (log_en && ram_we) glog.push_back(ram_addr[15:14] == 2'b11);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_ref_write(input logic [15:0] a, input logic [7:0] d);
    bit prot;
    prot = 1'b0;
`ifdef RAM_ARBITER_ROM_WP_EN
    prot = (a[15:14] == 2'b00);
`endif
    if (!prot) ref_mem[a] = d;
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick;
      if (cpu_ack) begin
        n = i;
        break;
      end
      chk("stall_waitn", cpu_wait_n, 0);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a,
                        input logic [7:0] d, input string tag);
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    #1 chk({tag, "_waitn0"}, cpu_wait_n, 0);
    wait_ack(10, n);
    chk({tag, "_lat"}, n, ACK_SAMPLES);
    if (n != 0) begin
      chk({tag, "_waitn1"}, cpu_wait_n, 1);
      if (!we) chk({tag, "_dout"}, cpu_dout, ref_mem[a]);
    end
    if (we) cpu_ref_write(a, d);
    cpu_req = 1'b0;
    tick;
    chk({tag, "_pulse"}, cpu_ack, 0);
  endtask

  task automatic spi_wr_ram(input logic [15:0] a, input logic [7:0] d);
    spi_wr = 1'b1; spi_addr = {16'h0000, a}; spi_din = d;
    tick;
    spi_wr = 1'b0;
    ref_mem[a] = d;
    repeat (3) tick;
  endtask

  task automatic spi_rd_ram(input logic [15:0] a, input string tag);
    int n;
    spi_rd = 1'b1; spi_addr = {16'h0000, a};
    tick;
    spi_rd = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      if (spi_rvalid) begin
        n = i;
        break;
      end
      tick;
    end
    chk({tag, "_rvalid"}, n != 0, 1);
    if (n != 0) chk({tag, "_dout"}, spi_dout, ref_mem[a]);
    tick;
  endtask

  task automatic spi_ctl_wr(input logic [7:0] d);
    spi_wr = 1'b1; spi_addr = 32'hFF00_0000; spi_din = d;
    tick;
    spi_wr = 1'b0;
    chk("ctl_wr", cpu_control, d);
  endtask

  initial begin
    int n, acks;
    logic [15:0] a, s1, s2, ca;
    logic [7:0] d, d2;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rvalid", spi_rvalid, 0);
    chk("rst_ovf", spi_ovf, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_ctl", cpu_control, 0);
    chk("rst_cdout", cpu_dout, 0);
    chk("rst_sdout", spi_dout, 0);
    chk("rst_waitn", cpu_wait_n, 1);
    tick;
    reset = 1'b0;
    tick;

    // CPU read of a preloaded location
    spi_wr_ram(16'h4000, 8'hA5);
    chk("pre_4000", mem_rd(16'h4000), 8'hA5);
    cpu_op(1'b0, 16'h4000, 8'h00, "rd4000");
    chk("rd4000_val", cpu_dout, 8'hA5);

    // Control register, loading stall, RAM write while loading
    spi_ctl_wr(8'h02);
    chk("load_waitn", cpu_wait_n, 0);
    spi_wr_ram(16'h5800, 8'h3C);
    chk("ram_5800", mem_rd(16'h5800), 8'h3C);
    spi_rd = 1'b1; spi_addr = 32'hFF00_0000;
    tick;
    spi_rd = 1'b0;
    chk("ctl_rvalid", spi_rvalid, 1);
    chk("ctl_rd", spi_dout, 8'h02);
    tick;
    chk("ctl_rvalid_pulse", spi_rvalid, 0);
    spi_wr = 1'b1; spi_addr = 32'h1200_5800; spi_din = 8'h77;
    tick;
    spi_wr = 1'b0;
    repeat (3) tick;
    chk("ign_ram", mem_rd(16'h5800), 8'h3C);
    chk("ign_ctl", cpu_control, 8'h02);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5800;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("ld_noack", cpu_ack, 0);
      chk("ld_waitn", cpu_wait_n, 0);
    end
    spi_ctl_wr(8'h00);
    wait_ack(10, n);
    chk("ld_ack", n != 0, 1);
    chk("ld_dout", cpu_dout, 8'h3C);
    cpu_req = 1'b0;
    tick;

    // Write-protect window
    cpu_op(1'b1, 16'h0010, 8'hFF, "wp");
    chk("wp_ram", mem_rd(16'h0010), ref_mem[16'h0010]);
`ifdef RAM_ARBITER_ROM_WP_EN
    chk("wp_prot", mem_rd(16'h0010), init_byte(16'h0010));
`else
    chk("wp_open", mem_rd(16'h0010), 8'hFF);
`endif

    // Random sequential traffic
    for (int k = 0; k < 16; k++) begin
      a = 16'($urandom);
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          cpu_op(1'b1, a, d, "rnd_cw");
          chk("rnd_cw_mem", mem_rd(a), ref_mem[a]);
        end
        1: cpu_op(1'b0, a, 8'h00, "rnd_cr");
        2: begin
          spi_wr_ram(a, d);
          chk("rnd_sw_mem", mem_rd(a), ref_mem[a]);
        end
        default: spi_rd_ram(a, "rnd_sr");
      endcase
    end

    // Continuous CPU demand with SPI writes every 4 cycles
    glog.delete();
    log_en = 1'b1;
    acks = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
        cpu_din = 8'($urandom);
        cpu_ref_write(cpu_addr, cpu_din);
      end else if (cpu_ack) begin
        acks++;
        if (c < 18) begin
          cpu_addr = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
          cpu_din = 8'($urandom);
          cpu_ref_write(cpu_addr, cpu_din);
        end else begin
          cpu_req = 1'b0;
        end
      end
      if (c % 4 == 2 && c <= 14) begin
        a = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
        spi_wr = 1'b1; spi_addr = {16'h0000, a}; spi_din = 8'($urandom);
        ref_mem[a] = spi_din;
      end else begin
        spi_wr = 1'b0;
      end
      tick;
    end
    log_en = 1'b0;
    chk("alt_acks", acks, 4);
    chk("alt_grants", glog.size(), 8);
    for (int i = 1; i < glog.size(); i++)
      chk("alt_order", glog[i] ^ glog[i-1], 1);
    chk("alt_ovf", spi_ovf, 0);
    for (int i = 16'h8000; i < 65536; i++)
      if (mem_rd(16'(i)) !== ref_mem[i]) chk("alt_mem", mem_rd(16'(i)), ref_mem[i]);
    chk("alt_mem_done", 1, 1 - errors + errors);

    // Two back-to-back strobes during a CPU access
    ca = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
    s1 = 16'hC000 | 16'($urandom_range(0, 16'h3FFE));
    s2 = s1 ^ 16'h0001;
    d  = 8'($urandom);
    d2 = ~ref_mem[s2];
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ca; cpu_din = 8'h96;
    tick;
    spi_wr = 1'b1; spi_addr = {16'h0000, s1}; spi_din = d;
    tick;
    spi_addr = {16'h0000, s2}; spi_din = d2;
    tick;
    spi_wr = 1'b0;
    chk("ovf_ack", cpu_ack, 1);
    chk("ovf_set", spi_ovf, 1);
    cpu_req = 1'b0;
    cpu_ref_write(ca, 8'h96);
    ref_mem[s1] = d;
    repeat (4) tick;
    chk("ovf_cpu_mem", mem_rd(ca), ref_mem[ca]);
    chk("ovf_s1_mem", mem_rd(s1), d);
    chk("ovf_s2_mem", mem_rd(s2), ref_mem[s2]);
    cpu_op(1'b0, s1, 8'h00, "ovf_rd");
    chk("ovf_sticky", spi_ovf, 1);

    // Reset in the middle of a CPU write
    ca = 16'h9123;
    d = ~ref_mem[ca];
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ca; cpu_din = d;
    tick;
    chk("mid_we", ram_we, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_din", ram_din, 0);
    chk("mid_rst_ovf", spi_ovf, 0);
    chk("mid_rst_ctl", cpu_control, 0);
    chk("mid_rst_cdout", cpu_dout, 0);
    chk("mid_rst_sdout", spi_dout, 0);
    chk("mid_rst_rvalid", spi_rvalid, 0);
    cpu_req = 1'b0;
    #1 chk("mid_rst_waitn", cpu_wait_n, 1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("mid_rst_ack", cpu_ack, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mid_post_ack", cpu_ack, 0);
    end
    chk("mid_mem", mem_rd(ca), ref_mem[ca]);
    cpu_op(1'b1, ca, 8'h3A, "post_wr");
    chk("post_mem", mem_rd(ca), 8'h3A);
    cpu_op(1'b0, ca, 8'h00, "post_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
